// File: rtl/simd_bram_pkg.sv
// Shared types, defaults and byte-lane helpers for the SIMD data-memory model.
// Helpers operate on MAX_DATA_W-wide words; callers cast to their own DATA_W.
// SIMD_BRAM_PARITY_EN: when defined, byte_parity() is used for per-byte parity.
package simd_bram_pkg;

    typedef enum logic [0:0] {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } wr_mode_e;

    localparam int unsigned DEF_MARKER   = 777;
    localparam logic [31:0] DEF_ERR_WORD = 32'hDEAD_BEEF;

    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

    // Replace each byte lane of old_w whose write enable is set with new_w.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_NB-1:0]     we
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_NB); i++) begin
            if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Even parity per byte: bit i makes byte i plus its parity bit even.
    function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DATA_W-1:0] w);
        logic [MAX_NB-1:0] p;
        for (int i = 0; i < int'(MAX_NB); i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/simd_bram_rd_pipe.sv
// Read pipeline of the SIMD BRAM model: RD_LAT-deep shift register of
// {data, valid, err[, par]} with synchronous clear on RST.
// Ports: CLK/RST, stage-0 inputs (valid_i, data_i, err_i[, par_i]) and the
// registered outputs dout_o (IDLE_WORD when invalid), valid_o, err_o[, par_o].
// SIMD_BRAM_PARITY_EN adds the parity-error lane.
module simd_bram_rd_pipe #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       RD_LAT    = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
`ifdef SIMD_BRAM_PARITY_EN
    input  logic              par_i,
    output logic              par_o,
`endif
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o,
    output logic              err_o
);

    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] data_d;
    logic              err_d;
`ifdef SIMD_BRAM_PARITY_EN
    logic [RD_LAT-1:0] par_q;
    logic              par_d;
`endif

    // Idle substitution happens on entry so every stage is already clean.
    always_comb begin
        data_d = valid_i ? data_i : IDLE_WORD;
        err_d  = valid_i && err_i;
`ifdef SIMD_BRAM_PARITY_EN
        par_d  = valid_i && par_i;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(RD_LAT); i++) data_q[i] <= IDLE_WORD;
            valid_q <= '0;
            err_q   <= '0;
`ifdef SIMD_BRAM_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            data_q[0]  <= data_d;
            valid_q[0] <= valid_i;
            err_q[0]   <= err_d;
`ifdef SIMD_BRAM_PARITY_EN
            par_q[0]   <= par_d;
`endif
            for (int i = 1; i < int'(RD_LAT); i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
`ifdef SIMD_BRAM_PARITY_EN
                par_q[i]   <= par_q[i-1];
`endif
            end
        end
    end

    assign dout_o  = data_q[RD_LAT-1];
    assign valid_o = valid_q[RD_LAT-1];
    assign err_o   = err_q[RD_LAT-1];
`ifdef SIMD_BRAM_PARITY_EN
    assign par_o   = par_q[RD_LAT-1];
`endif

endmodule

// File: rtl/simd_bram_model.sv
// Word-addressed BRAM model feeding the SIMD datapath.
// Ports: CLK, RST (sync, active-high); en/we/addr/din request; dout,
// dout_valid, addr_err read result RD_LAT cycles after the request.
// Byte-lane writes, configurable read-during-write, out-of-range detection.
// SIMD_BRAM_PARITY_EN adds per-byte even parity, par_err output and the
// inject_par_flip(addr, lane) task.
module simd_bram_model
    import simd_bram_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 50,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RD_LAT    = 2,
    parameter int unsigned       WR_MODE   = 0,
    parameter logic [DATA_W-1:0] MARKER    = DATA_W'(DEF_MARKER),
    parameter logic [DATA_W-1:0] IDLE_WORD = '0,
    parameter logic [DATA_W-1:0] ERR_WORD  = DATA_W'(DEF_ERR_WORD)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
`ifdef SIMD_BRAM_PARITY_EN
    output logic                par_err,
`endif
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                addr_err
);

    localparam int unsigned       NB      = DATA_W / 8;
    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam wr_mode_e          MODE    = (WR_MODE == 1) ? WRITE_FIRST : READ_FIRST;

    // Array holds the XOR delta against the boot image. Being 2-state it
    // starts at zero, so the boot image is visible from time 0 and RST
    // never disturbs memory contents.
    bit [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic [DATA_W-1:0] boot_word(input logic [IDX_W-1:0] i);
        return (i == '0 || i == IDX_W'(DEPTH - 1)) ? MARKER : '0;
    endfunction

    logic              acc;
    logic              in_range;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;

    // Request decode and memory-stage read data.
    always_comb begin
        acc      = en && !RST;
        in_range = addr < DEPTH_A;
        idx      = in_range ? IDX_W'(addr) : '0;
        old_word = mem_q[idx] ^ boot_word(idx);
        merged   = DATA_W'(byte_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(din), MAX_NB'(we)));
        wr_en    = acc && in_range && (we != '0);
        if (!in_range)                           rd_word = ERR_WORD;
        else if (MODE == WRITE_FIRST && we != '0) rd_word = merged;
        else                                     rd_word = old_word;
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_en) mem_q[idx] <= merged ^ boot_word(idx);
    end

`ifdef SIMD_BRAM_PARITY_EN
    // Stored parity = par_q ^ boot parity ^ par_flip; writes fold the current
    // flip in so a rewritten lane reads back with correct parity.
    bit [NB-1:0] par_q    [DEPTH];
    bit [NB-1:0] par_flip [DEPTH];

    logic [NB-1:0] boot_par;
    logic [NB-1:0] stored_par;
    logic [NB-1:0] chk_mask;
    logic          par_bad;

    always_comb begin
        boot_par   = NB'(byte_parity(MAX_DATA_W'(boot_word(idx))));
        stored_par = par_q[idx] ^ boot_par ^ par_flip[idx];
        chk_mask   = (MODE == WRITE_FIRST) ? ~we : '1;
        par_bad    = in_range &&
                     (((NB'(byte_parity(MAX_DATA_W'(old_word))) ^ stored_par) & chk_mask) != '0);
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            par_q[idx] <= (par_q[idx] & ~we) |
                          ((NB'(byte_parity(MAX_DATA_W'(merged))) ^ boot_par ^ par_flip[idx]) & we);
        end
    end

    task automatic inject_par_flip(input logic [ADDR_W-1:0] a, input int unsigned lane);
        if (a < DEPTH_A && lane < NB) begin
            par_flip[IDX_W'(a)][lane] = ~par_flip[IDX_W'(a)][lane];
        end
    endtask
`endif

    simd_bram_rd_pipe #(
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .IDLE_WORD (IDLE_WORD)
    ) u_rd_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .valid_i (acc),
        .data_i  (rd_word),
        .err_i   (!in_range),
`ifdef SIMD_BRAM_PARITY_EN
        .par_i   (par_bad),
        .par_o   (par_err),
`endif
        .dout_o  (dout),
        .valid_o (dout_valid),
        .err_o   (addr_err)
    );

endmodule
